memory_bus_unit: RTL

Unified 16x8 program/data memory that answers the processor controller's bus strobes. It is the responder side of the controller-to-memory interface: it returns the byte at `address` when the controller enables memory onto the bus, and commits bus data when the controller loads memory with `write` set. After reset it first runs a boot phase that streams the program image in over a valid/ready port. It also enforces a write-protected program region and latches sticky fault flags for protocol violations.

---
 rtl/memory_bus_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/memory_bus_unit.sv
// Unified program/data memory responding to the controller's bus strobes.
// After reset it loads its image over a valid/ready boot port, then serves reads and writes.
module memory_bus_unit #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int PROTECT_TOP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic              memory_enable_bus,
    input  logic              memory_load_bus,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    input  logic              boot_valid,
    input  logic [DATA_W-1:0] boot_data,
    input  logic              boot_last,
    output logic              boot_ready,
    output logic              boot_done,
    input  logic              fault_clr,
    output logic [2:0]        fault
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] boot_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              boot_xfer;
    logic              boot_end;
    logic              run_write;
    logic [2:0]        fault_event;

    // A compare against an int keeps PROTECT_TOP >= DEPTH meaningful (all read-only).
    function automatic logic is_protected(input logic [ADDR_W-1:0] a);
        return int'(a) < PROTECT_TOP;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        boot_xfer   = 1'b0;
        boot_end    = 1'b0;
        run_write   = 1'b0;
        fault_event = 3'b000;
        case (state)
            BOOT: begin
                boot_xfer = boot_valid;
                boot_end  = boot_last || (boot_ptr == ADDR_W'(DEPTH - 1));
                if (boot_xfer && boot_end) begin
                    state_next = RUN;
                end
                fault_event[2] = memory_enable_bus || memory_load_bus;
            end
            RUN: begin
                // A load during a read is a bus conflict and is never committed.
                if (memory_enable_bus && memory_load_bus) begin
                    fault_event[0] = 1'b1;
                end else if (memory_load_bus && write) begin
                    if (is_protected(address)) begin
                        fault_event[1] = 1'b1;
                    end else begin
                        run_write = 1'b1;
                    end
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boot_ptr <= '0;
        end else if (boot_xfer && !boot_end) begin
            boot_ptr <= boot_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (boot_xfer) begin
            mem[boot_ptr] <= boot_data;
        end else if (run_write) begin
            mem[address] <= bus_in;
        end
    end

    // A clear and a new event on the same edge leave only the new event's bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 3'b000;
        end else begin
            fault <= (fault_clr ? 3'b000 : fault) | fault_event;
        end
    end

    assign bus_out    = (state == RUN && memory_enable_bus) ? mem[address] : '0;
    assign boot_ready = (state == BOOT);
    assign boot_done  = (state == RUN);

endmodule
